serial_adder_core: RTL and testbench

Parametrised bit-serial adder/subtractor with its control FSM, bit counter and operand/result shift registers in one block. It is the successor to the fixed two-bit-state serial adder FSM: width-generic, with add/subtract modes, a busy/done handshake and registered results. It sits between a register-file front end and any consumer of `sum`/`cout`, trading area for WIDTH+1 cycles of latency.

---
 rtl/serial_adder_core.sv | 112 +++++++++++
 tb/tb_serial_adder_core.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_core.sv
// serial_adder_core: bit-serial add/sub, LSB first, result after WIDTH+1 cycles.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module serial_adder_core #(
  parameter int WIDTH = 8,
  parameter int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic [1:0]       state
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] ADD  = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             carry;
  logic [CNT_W-1:0] count;

  logic             s;
  logic             c_nxt;
  logic             last;
  logic [WIDTH:0]   res_cat;
  logic [WIDTH-1:0] res_nxt;

  assign s       = a_sh[0] ^ b_sh[0] ^ carry;
  assign c_nxt   = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) |
                   (b_sh[0] & carry);
  assign last    = (count == CNT_W'(WIDTH - 1));
  // concat-then-slice keeps the MSB insert legal at WIDTH = 1
  assign res_cat = {s, res_sh};
  assign res_nxt = res_cat[WIDTH:1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = IDLE;
    unique case (state_q)
      IDLE:    state_d = go ? ADD : IDLE;
      ADD:     state_d = last ? DONE : ADD;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy  = 1'b0;
    done  = 1'b0;
    state = state_q;
    unique case (state_q)
      ADD:     busy = 1'b1;
      DONE:    begin busy = 1'b1; done = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      count  <= '0;
      sum    <= '0;
      cout   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf    <= 1'b0;
`endif
    end else if (state_q == IDLE) begin
      if (go) begin
        a_sh  <= a;
        b_sh  <= sub ? ~b : b;
        carry <= sub ? 1'b1 : cin;
        count <= '0;
      end
    end else if (state_q == ADD) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      res_sh <= res_nxt;
      carry  <= c_nxt;
      if (last) begin
        sum  <= res_nxt;
        cout <= c_nxt;
`ifdef SERIAL_ADDER_OVF_EN
        ovf  <= carry ^ c_nxt;
`endif
      end else begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_core.sv
// tb_serial_adder_core: random and directed checks of serial_adder_core
// at WIDTH 8 and WIDTH 1 against an arithmetic reference model.
module tb_serial_adder_core;

  logic       clk = 1'b0;
  logic       rst;
  logic       go, sub, cin;
  logic [7:0] a, b;
  logic       busy, done, cout;
  logic [7:0] sum;
  logic [1:0] state;
  logic       go1, sub1, cin1;
  logic [0:0] a1, b1;
  logic       busy1, done1, cout1;
  logic [0:0] sum1;
  logic [1:0] state1;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf, ovf1;
`endif

  int tests = 0;
  int fails = 0;
  logic [7:0] last_sum;

  always #5 clk = ~clk;

  serial_adder_core #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .go(go), .sub(sub), .a(a), .b(b),
    .cin(cin), .busy(busy), .done(done), .sum(sum), .cout(cout),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf(ovf),
`endif
    .state(state)
  );

  serial_adder_core #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .go(go1), .sub(sub1), .a(a1), .b(b1),
    .cin(cin1), .busy(busy1), .done(done1), .sum(sum1),
    .cout(cout1),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf(ovf1),
`endif
    .state(state1)
  );

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {cout, sum}: add is plain a+b+cin, sub gives a-b with cout = no borrow
  function automatic logic [8:0] model(input logic s, input logic [7:0] x,
                                       input logic [7:0] y, input logic c);
    int r;
    if (s) begin
      r = int'(x) - int'(y);
      return {x >= y, 8'(r & 255)};
    end
    r = int'(x) + int'(y) + int'(c);
    return 9'(r);
  endfunction

  function automatic logic model_ovf(input logic s, input logic [7:0] x,
                                     input logic [7:0] y, input logic c);
    int sx, sy, r;
    sx = int'($signed(x));
    sy = int'($signed(y));
    r = s ? sx - sy : sx + sy + int'(c);
    return (r > 127) || (r < -128);
  endfunction

  task automatic run_op(input logic s, input logic [7:0] x,
                        input logic [7:0] y, input logic c);
    logic [8:0] e;
    int cyc, bz;
    e = model(s, x, y, c);
    @(negedge clk);
    go = 1'b1; sub = s; a = x; b = y; cin = c;
    @(posedge clk); #1;
    go = 1'b0; sub = 1'($urandom);
    a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
    cyc = 0;
    bz = busy ? 1 : 0;
    while (!done && cyc < 12) begin
      check("sum_held", {56'd0, sum}, {56'd0, last_sum});
      @(posedge clk); #1;
      cyc++;
      if (busy) bz++;
    end
    check("latency", 64'(cyc), 64'd8);
    check("busy_len", 64'(bz), 64'd9);
    check("sum", {56'd0, sum}, {56'd0, e[7:0]});
    check("cout", {63'd0, cout}, {63'd0, e[8]});
`ifdef SERIAL_ADDER_OVF_EN
    check("ovf", {63'd0, ovf}, {63'd0, model_ovf(s, x, y, c)});
`endif
    last_sum = e[7:0];
    @(posedge clk); #1;
    check("done_pulse", {63'd0, done}, 64'd0);
    check("idle", {62'd0, state}, 64'd0);
  endtask

  initial begin
    logic [8:0] e;
    logic [8:0] q [$];
    rst = 1'b1; go = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    go1 = 1'b0; sub1 = 1'b0; cin1 = 1'b0; a1 = '0; b1 = '0;
    last_sum = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", {62'd0, state}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_sum", {56'd0, sum}, 64'd0);
    check("rst_cout", {63'd0, cout}, 64'd0);
    @(negedge clk); rst = 1'b0;

    run_op(1'b0, 8'h5A, 8'h3C, 1'b0);
    run_op(1'b0, 8'hFF, 8'h01, 1'b0);
    run_op(1'b0, 8'h00, 8'h00, 1'b1);
    run_op(1'b1, 8'h10, 8'h20, 1'b1);
    run_op(1'b1, 8'h20, 8'h10, 1'b0);
    run_op(1'b0, 8'h7F, 8'h01, 1'b0);
    run_op(1'b0, 8'h80, 8'h80, 1'b0);
    for (int i = 0; i < 20; i++)
      run_op(1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));

    // go held high, inputs scrambled every cycle
    go = 1'b1;
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 10; j++) begin
        @(negedge clk);
        sub = 1'($urandom); a = 8'($urandom);
        b = 8'($urandom); cin = 1'($urandom);
        if (j == 0) q.push_back(model(sub, a, b, cin));
        @(posedge clk); #1;
        if (j == 8) begin
          e = q.pop_front();
          check("hold_done", {63'd0, done}, 64'd1);
          check("hold_sum", {56'd0, sum}, {56'd0, e[7:0]});
          check("hold_cout", {63'd0, cout}, {63'd0, e[8]});
          last_sum = e[7:0];
        end else begin
          check("hold_nodone", {63'd0, done}, 64'd0);
          check("hold_keep", {56'd0, sum}, {56'd0, last_sum});
        end
      end
    end
    go = 1'b0;
    @(posedge clk); #1;

    // asynchronous reset four cycles into ADD
    @(negedge clk);
    go = 1'b1; sub = 1'b0; a = 8'h33; b = 8'h44; cin = 1'b0;
    @(posedge clk); #1; go = 1'b0;
    repeat (4) @(posedge clk);
    #3; rst = 1'b1; #1;
    check("arst_state", {62'd0, state}, 64'd0);
    check("arst_busy", {63'd0, busy}, 64'd0);
    check("arst_done", {63'd0, done}, 64'd0);
    check("arst_sum", {56'd0, sum}, 64'd0);
    check("arst_cout", {63'd0, cout}, 64'd0);
`ifdef SERIAL_ADDER_OVF_EN
    check("arst_ovf", {63'd0, ovf}, 64'd0);
`endif
    @(negedge clk); rst = 1'b0;
    last_sum = '0;
    run_op(1'b0, 8'h01, 8'h02, 1'b0);

    // WIDTH = 1: 1+1 then 0-1
    @(negedge clk);
    go1 = 1'b1; sub1 = 1'b0; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b0;
    @(posedge clk); #1; go1 = 1'b0;
    check("w1_busy", {63'd0, busy1}, 64'd1);
    check("w1_early", {63'd0, done1}, 64'd0);
    @(posedge clk); #1;
    check("w1_done", {63'd0, done1}, 64'd1);
    check("w1_sum", {63'd0, sum1}, 64'd0);
    check("w1_cout", {63'd0, cout1}, 64'd1);
`ifdef SERIAL_ADDER_OVF_EN
    check("w1_ovf", {63'd0, ovf1}, 64'd1);
`endif
    @(posedge clk); #1;
    check("w1_pulse", {63'd0, done1}, 64'd0);
    @(negedge clk);
    go1 = 1'b1; sub1 = 1'b1; a1 = 1'b0; b1 = 1'b1; cin1 = 1'b0;
    @(posedge clk); #1; go1 = 1'b0;
    @(posedge clk); #1;
    check("w1s_done", {63'd0, done1}, 64'd1);
    check("w1s_sum", {63'd0, sum1}, 64'd1);
    check("w1s_cout", {63'd0, cout1}, 64'd0);
`ifdef SERIAL_ADDER_OVF_EN
    check("w1s_ovf", {63'd0, ovf1}, 64'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
